// File: rtl/lvds_rx_pkg.sv
// rtl/lvds_rx_pkg.sv - shared constants and FSM state type for the LVDS word aligner
package lvds_rx_pkg;

  localparam int                       LVDS_DATA_W    = 7;
  localparam logic [LVDS_DATA_W-1:0]   LVDS_TRAIN_PAT = 7'b1100011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

endpackage

// File: rtl/lvds_rx_word_align_if.sv
// rtl/lvds_rx_word_align_if.sv - deserializer link and payload signal bundle for the word aligner
interface lvds_rx_word_align_if
  import lvds_rx_pkg::*;
#(
  parameter int DATA_W = LVDS_DATA_W
);

  logic              train_en;
  logic [DATA_W-1:0] rx_data;
  logic              bitslip;
  logic [2:0]        slip_count;
  logic              aligned;
  logic              align_err;
  logic [DATA_W-1:0] rx_word;
  logic              rx_valid;

  modport slave (
    input  train_en, rx_data,
    output bitslip, slip_count, aligned, align_err, rx_word, rx_valid
  );

  modport master (
    output train_en, rx_data,
    input  bitslip, slip_count, aligned, align_err, rx_word, rx_valid
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lvds_rx_word_align.sv
// rtl/lvds_rx_word_align.sv - finds the word boundary of a 7:1 LVDS link by bitslipping
// until the training pattern is seen LOCK_CNT times in a row, then forwards payload
module lvds_rx_word_align
  import lvds_rx_pkg::*;
#(
  parameter int                DATA_W    = LVDS_DATA_W,
  parameter logic [DATA_W-1:0] TRAIN_PAT = LVDS_TRAIN_PAT,
  parameter int                LOCK_CNT  = 16,
  parameter int                LOSS_CNT  = 4,
  parameter int                SLIP_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  lvds_rx_word_align_if.slave  link
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);
  localparam int AW = $clog2(DATA_W + 1);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  state_e            state_q,      state_d;
  logic [MW-1:0]     match_cnt_q,  match_cnt_d;
  logic [LW-1:0]     loss_cnt_q,   loss_cnt_d;
  logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
  logic [AW-1:0]     attempt_q,    attempt_d;
  logic [2:0]        slip_cnt_q,   slip_cnt_d;
  logic [DATA_W-1:0] rx_word_q,    rx_word_d;
  logic              rx_valid_q,   rx_valid_d;
  logic              pat_match;

  assign pat_match = (link.rx_data == TRAIN_PAT);

  always_comb begin
    state_d      = state_q;
    match_cnt_d  = match_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    settle_cnt_d = settle_cnt_q;
    attempt_d    = attempt_q;
    slip_cnt_d   = slip_cnt_q;
    rx_word_d    = rx_word_q;
    rx_valid_d   = 1'b0;

    // Losing the PLL overrides every other transition.
    if (!lock_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (link.train_en) begin
            state_d     = ST_CHECK;
            match_cnt_d = '0;
            slip_cnt_d  = '0;
            attempt_d   = '0;
          end
        end

        ST_CHECK: begin
          if (!link.train_en) begin
            state_d = ST_IDLE;
          end else if (pat_match) begin
            if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
              state_d    = ST_LOCKED;
              loss_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + MW'(1);
            end
          end else begin
            match_cnt_d = '0;
            state_d     = (attempt_q < AW'(DATA_W)) ? ST_SLIP : ST_ERROR;
          end
        end

        ST_SLIP: begin
          slip_cnt_d   = (slip_cnt_q == 3'(DATA_W - 1)) ? 3'd0 : slip_cnt_q + 3'd1;
          attempt_d    = attempt_q + AW'(1);
          settle_cnt_d = '0;
          state_d      = link.train_en ? ST_SETTLE : ST_IDLE;
        end

        ST_SETTLE: begin
          if (!link.train_en) begin
            state_d = ST_IDLE;
          end else if (settle_cnt_q == SW'(SLIP_WAIT - 1)) begin
            state_d     = ST_CHECK;
            match_cnt_d = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + SW'(1);
          end
        end

        ST_LOCKED: begin
          if (link.train_en) begin
            if (pat_match) begin
              loss_cnt_d = '0;
            end else if (loss_cnt_q == LW'(LOSS_CNT - 1)) begin
              // Re-acquire from the current boundary with a fresh set of attempts.
              state_d     = ST_CHECK;
              match_cnt_d = '0;
              attempt_d   = '0;
              loss_cnt_d  = '0;
            end else begin
              loss_cnt_d = loss_cnt_q + LW'(1);
            end
          end else begin
            rx_word_d  = link.rx_data;
            rx_valid_d = 1'b1;
            loss_cnt_d = '0;
          end
        end

        ST_ERROR: begin
          if (!link.train_en) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      match_cnt_q  <= '0;
      loss_cnt_q   <= '0;
      settle_cnt_q <= '0;
      attempt_q    <= '0;
      slip_cnt_q   <= '0;
      rx_word_q    <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      attempt_q    <= attempt_d;
      slip_cnt_q   <= slip_cnt_d;
      rx_word_q    <= rx_word_d;
      rx_valid_q   <= rx_valid_d;
    end
  end

  // SLIP always lasts exactly one cycle, so decoding it yields a single-cycle pulse.
  assign link.bitslip    = (state_q == ST_SLIP);
  assign link.aligned    = (state_q == ST_LOCKED);
  assign link.align_err  = (state_q == ST_ERROR);
  assign link.slip_count = slip_cnt_q;
  assign link.rx_word    = rx_word_q;
  assign link.rx_valid   = rx_valid_q;

endmodule

// File: tb/tb_lvds_rx_word_align.sv
// tb/tb_lvds_rx_word_align.sv - directed self-checking bench for lvds_rx_word_align
module tb_lvds_rx_word_align;
  import lvds_rx_pkg::*;

  localparam logic [6:0] TP = 7'b1100011;

  logic clk;
  logic rst_n;
  logic pll_locked;

  lvds_rx_word_align_if #(.DATA_W(7)) link ();

  lvds_rx_word_align dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .link       (link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int mode;          // 0 = rotated pattern, 1 = random non-pattern, 2 = payload ramp
  int off;
  int corrupt;
  int pay;
  int cyc;
  int n_slips;
  int last_slip;
  int min_gap;
  int back2back;
  logic prev_bitslip;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] rot(input int k);
    logic [13:0] t;
    t = {TP, TP};
    return t[13-k -: 7];
  endfunction

  task automatic drive();
    logic [6:0] r;
    case (mode)
      0: begin
        link.rx_data = (corrupt > 0) ? ~rot(off) : rot(off);
        if (corrupt > 0) corrupt--;
      end
      1: begin
        do r = 7'($urandom_range(0, 127)); while (r == TP);
        link.rx_data = r;
      end
      default: begin
        link.rx_data = 7'(pay);
        pay++;
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (link.bitslip) begin
      if (prev_bitslip) back2back++;
      if (n_slips > 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
      n_slips++;
      last_slip = cyc;
      off = (off == 0) ? 6 : off - 1;
    end
    prev_bitslip = link.bitslip;
    drive();
  endtask

  task automatic clear_model(input int start_off);
    off = start_off; corrupt = 0; n_slips = 0; last_slip = 0;
    min_gap = 1000; back2back = 0; prev_bitslip = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    cyc = 0; pay = 0; mode = 0;
    clear_model(0);
    rst_n = 1'b0; pll_locked = 1'b1; link.train_en = 1'b1;
    link.rx_data = rot(0);

    // Reset values and lock latency on an already-aligned link
    step(); step();
    check("rst_aligned",   32'(link.aligned),    32'd0);
    check("rst_bitslip",   32'(link.bitslip),    32'd0);
    check("rst_align_err", 32'(link.align_err),  32'd0);
    check("rst_rx_valid",  32'(link.rx_valid),   32'd0);
    check("rst_rx_word",   32'(link.rx_word),    32'd0);
    check("rst_slip_cnt",  32'(link.slip_count), 32'd0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (link.aligned) begin n = i; break; end
    end
    check("lock_latency", 32'(n), 32'd19);
    check("lock_noslip", 32'(n_slips), 32'd0);

    // Loss tolerance: three bad words survive, the fourth drops lock
    corrupt = 3; drive();
    step(); step(); step();
    check("loss3_aligned", 32'(link.aligned), 32'd1);
    step(); step();
    check("loss3_still", 32'(link.aligned), 32'd1);
    corrupt = 4; drive();
    step(); step(); step();
    check("loss4_pre", 32'(link.aligned), 32'd1);
    step();
    check("loss4_drop", 32'(link.aligned), 32'd0);
    for (int i = 0; i < 15; i++) step();
    check("relock_early", 32'(link.aligned), 32'd0);
    step();
    check("relock", 32'(link.aligned), 32'd1);

    // Payload pass-through with one-cycle latency
    link.train_en = 1'b0; mode = 2; pay = 0; drive();
    for (int i = 0; i < 128; i++) begin
      step();
      check("pay_valid", 32'(link.rx_valid), 32'd1);
      check("pay_word",  32'(link.rx_word),  32'(i));
    end
    check("pay_aligned", 32'(link.aligned), 32'd1);

    // PLL loss while LOCKED
    pll_locked = 1'b0;
    step(); step(); step();
    check("pll_locked_valid",   32'(link.rx_valid), 32'd0);
    check("pll_locked_aligned", 32'(link.aligned),  32'd0);
    check("pll_locked_idle",    32'(dut.state_q),   32'(ST_IDLE));

    // Rotated by 3: exactly three spaced bitslips then lock
    pll_locked = 1'b1; link.train_en = 1'b1; mode = 0;
    clear_model(3); drive();
    do_reset();
    for (int i = 0; i < 200 && !link.aligned; i++) step();
    check("rot3_aligned",  32'(link.aligned),    32'd1);
    check("rot3_slips",    32'(n_slips),         32'd3);
    check("rot3_slip_cnt", 32'(link.slip_count), 32'd3);
    check("rot3_gap_ok",   32'(min_gap >= 5),    32'd1);
    check("rot3_b2b",      32'(back2back),       32'd0);

    // PLL loss while SETTLE
    clear_model(3); drive();
    do_reset();
    for (int i = 0; i < 40 && n_slips == 0; i++) step();
    step();
    check("settle_pre", 32'(dut.state_q), 32'(ST_SETTLE));
    pll_locked = 1'b0;
    step(); step(); step();
    check("settle_pll_idle",    32'(dut.state_q),   32'(ST_IDLE));
    check("settle_pll_aligned", 32'(link.aligned),  32'd0);
    check("settle_pll_bitslip", 32'(link.bitslip),  32'd0);

    // Reset in the middle of a bitslip pulse
    pll_locked = 1'b1;
    clear_model(3); drive();
    do_reset();
    for (int i = 0; i < 40 && !link.bitslip; i++) step();
    check("slip_seen", 32'(link.bitslip), 32'd1);
    rst_n = 1'b0;
    step();
    check("rst_mid_slip", 32'(link.bitslip), 32'd0);
    rst_n = 1'b1;

    // Never-matching data: seven slips, then sticky error until training stops
    mode = 1; clear_model(0); drive();
    do_reset();
    for (int i = 0; i < 300 && !link.align_err; i++) step();
    check("err_flag",  32'(link.align_err), 32'd1);
    check("err_slips", 32'(n_slips),        32'd7);
    step(); step(); step(); step(); step(); step();
    check("err_sticky",  32'(link.align_err), 32'd1);
    check("err_noslip",  32'(n_slips),        32'd7);
    check("err_b2b",     32'(back2back),      32'd0);
    link.train_en = 1'b0;
    step();
    check("err_clear", 32'(link.align_err), 32'd0);
    check("err_idle",  32'(dut.state_q),    32'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lvds_rx_word_align.md
LVDS_RX_WORD_ALIGN -- requirements
Module: lvds_rx_word_align

Interface
REQ-001 Parameter DATA_W, 7, deserialized word width in bits (7:1 LVDS).
REQ-002 Parameter TRAIN_PAT, 7'b1100011, training word expected on the link during alignment.
REQ-003 Parameter LOCK_CNT, 16, consecutive matches required to declare alignment.
REQ-004 Parameter LOSS_CNT, 4, consecutive mismatches during training that drop alignment.
REQ-005 Parameter SLIP_WAIT, 4, settle cycles after each bitslip pulse.
REQ-006 clk  in  1  deserializer parallel clock from the source-synchronous PLL; one clock, all logic on rising edge.
REQ-007 rst_n  in  1  reset, synchronous and active-low.
REQ-008 pll_locked  in  1  PLL lock indicator, asynchronous to clk.
REQ-009 train_en  in  1  high = link is sending TRAIN_PAT; low = payload mode.
REQ-010 rx_data  in  DATA_W  raw deserializer word.
REQ-011 bitslip  out  1  one-cycle pulse to the deserializer bitslip input.
REQ-012 slip_count  out  3  bitslips issued since the last IDLE exit, modulo DATA_W.
REQ-013 aligned  out  1  word boundary is locked.
REQ-014 align_err  out  1  sticky: all DATA_W positions tried without lock.
REQ-015 rx_word  out  DATA_W  registered payload word.
REQ-016 rx_valid  out  1  rx_word qualifier.

Function
REQ-017 pll_locked SHALL pass through a 2-flop synchronizer; lock_s denotes the synchronized value.
REQ-018 FSM states SHALL be IDLE, CHECK, SLIP, SETTLE, LOCKED, ERROR; all transitions registered.
REQ-019 IDLE -> CHECK when lock_s=1 and train_en=1; on entry match_cnt=0, slip_count=0, attempt_cnt=0.
REQ-020 CHECK: rx_data==TRAIN_PAT increments match_cnt; the LOCK_CNT-th consecutive match SHALL move to LOCKED next cycle.
REQ-021 CHECK: a mismatch SHALL move to SLIP if attempt_cnt<DATA_W, else to ERROR.
REQ-022 SLIP: bitslip=1 for exactly one cycle; slip_count increments with wrap 6->0; attempt_cnt increments; next state SETTLE.
REQ-023 SETTLE: hold for SLIP_WAIT cycles ignoring rx_data, then CHECK with match_cnt=0.
REQ-024 LOCKED: aligned=1; with train_en=1, count consecutive mismatches; LOSS_CNT consecutive mismatches -> CHECK, aligned=0 next cycle; any match clears the count.
REQ-025 LOCKED with train_en=0: rx_word<=rx_data, rx_valid=1, latency one clk; no pattern checking.
REQ-026 rx_valid SHALL be 0 in every state other than LOCKED-with-train_en=0.
REQ-027 ERROR: align_err=1, bitslip=0; leaves to IDLE only when train_en=0; align_err clears on that exit.
REQ-028 lock_s=0 in any state SHALL force IDLE next cycle with aligned=0, rx_valid=0; this takes priority over all other transitions.
REQ-029 bitslip SHALL never be asserted on two consecutive cycles nor outside SLIP.
REQ-030 train_en falling in CHECK/SLIP/SETTLE SHALL return to IDLE; an in-flight bitslip pulse completes its single cycle.

Reset
REQ-031 rst_n=0 at a clk edge: state=IDLE, synchronizer flops=0, all counters=0, bitslip=0, aligned=0, align_err=0, rx_valid=0, rx_word=0, slip_count=0.
REQ-032 Reset asserted mid-SLIP SHALL drop bitslip the same edge.

Structure
REQ-033 State enum, TRAIN_PAT default and DATA_W SHALL live in shared package lvds_rx_pkg.
REQ-034 The pll_locked synchronizer SHALL be a sub-module named sync_2ff; all else is flat.

Verification
REQ-035 Aligned pattern, pll_locked=1, train_en=1 from reset release -> aligned=1 exactly 17+2 (sync) cycles after release, bitslip never pulses.
REQ-036 Pattern rotated by 3 bits (model slips) -> exactly 3 bitslip pulses each separated by >=SLIP_WAIT+1 cycles, slip_count=3, aligned=1.
REQ-037 Random non-pattern data -> 7 bitslips, then align_err=1; drop train_en -> align_err=0, state IDLE.
REQ-038 LOCKED, train_en=1, inject 3 then 4 consecutive corrupt words -> aligned stays 1 after 3, drops after 4th.
REQ-039 LOCKED, train_en=0, payload 0x00..0x7F -> rx_word equals rx_data delayed 1 cycle, rx_valid=1 every cycle.
REQ-040 pll_locked deasserted mid-SETTLE and mid-LOCKED -> aligned/rx_valid 0 within 3 cycles, state IDLE; rst_n pulse mid-SLIP -> bitslip 0 next edge.
